// File: rtl/intersection_phase_scheduler.sv
// Round-robin right-of-way scheduler for an N-approach intersection.
// Handles min/max green, yellow/all-red clearance and emergency pre-emption.
//
// state  | meaning
// IDLE   | all red, nothing requested
// GREEN  | grant_id has green
// YELLOW | grant_id clearing on yellow
// ALLRED | all red clearance before the next grant
module intersection_phase_scheduler #(
    parameter int N_APPR      = 4,
    parameter int TICK_DIV    = 50000000,
    parameter int MIN_GREEN   = 5,
    parameter int MAX_GREEN   = 30,
    parameter int YEL_TIME    = 3,
    parameter int ALLRED_TIME = 1,
    parameter int CW          = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_APPR-1:0]           req,
    input  logic                        emg_valid,
    input  logic [$clog2(N_APPR)-1:0]   emg_id,
    output logic [3*N_APPR-1:0]         light,
    output logic [$clog2(N_APPR)-1:0]   grant_id,
    output logic                        grant_vld,
    output logic                        emg_active
);
    localparam int IW = $clog2(N_APPR);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GREEN, S_YELLOW, S_ALLRED} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   presc;
    logic            tick;
    logic [CW-1:0]   timer;
    logic [IW-1:0]   ptr, ptr_nxt, grant_nxt;
    logic            emg_nxt;
    logic            emg_ok;
    logic            win_found, win_emg;
    logic [IW-1:0]   win_id, idx;
    logic            own_req, others_any;
    logic            take;

    assign tick       = (presc == PW'(TICK_DIV - 1));
    assign emg_ok     = emg_valid && ({1'b0, emg_id} < (IW+1)'(N_APPR));
    assign own_req    = req[grant_id];
    assign others_any = |(req & ~(N_APPR'(1) << grant_id));
    assign grant_vld  = (state == S_GREEN) || (state == S_YELLOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Descending scan so the lowest offset from ptr (highest priority) is assigned last.
    always_comb begin
        win_found = 1'b0;
        win_emg   = 1'b0;
        win_id    = '0;
        idx       = '0;
        if (emg_ok) begin
            win_found = 1'b1;
            win_emg   = 1'b1;
            win_id    = emg_id;
        end else begin
            for (int i = N_APPR; i >= 1; i--) begin
                idx = IW'((int'(ptr) + i) % N_APPR);
                if (req[idx]) begin
                    win_found = 1'b1;
                    win_id    = idx;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        ptr_nxt   = ptr;
        emg_nxt   = emg_active;
        take      = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_found) take = 1'b1;
            end
            S_GREEN: begin
                if (emg_ok) begin
                    if (emg_id != grant_id) state_nxt = S_YELLOW;
                end else if (others_any &&
                             ((timer >= CW'(MIN_GREEN) && !own_req) ||
                              timer >= CW'(MAX_GREEN))) begin
                    state_nxt = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (tick && timer == CW'(YEL_TIME - 1)) state_nxt = S_ALLRED;
            end
            S_ALLRED: begin
                if (tick && timer == CW'(ALLRED_TIME - 1)) begin
                    if (win_found) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        emg_nxt   = 1'b0;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (take) begin
            state_nxt = S_GREEN;
            grant_nxt = win_id;
            ptr_nxt   = win_id;
            emg_nxt   = win_emg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            grant_id   <= '0;
            ptr        <= IW'(N_APPR - 1);
            emg_active <= 1'b0;
            timer      <= '0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            ptr        <= ptr_nxt;
            emg_active <= emg_nxt;
            if (state_nxt != state) begin
                timer <= '0;
            end else if (tick && !(&timer)) begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_APPR; i++) begin
            light[3*i +: 3] = 3'b100;
        end
        if (grant_vld) begin
            light[3*int'(grant_id) +: 3] = (state == S_GREEN) ? 3'b001 : 3'b010;
        end
    end
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: stimulus queues expected lamp phases, a monitor pops one per output change
// and checks its contents, the length of the phase it replaced, and the single-lamp invariant.
module tb_intersection_phase_scheduler;
    localparam logic [11:0] ALL_RED = 12'h924;
    localparam int BIG = 1000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic        emg_valid = 1'b0;
    logic [1:0]  emg_id = '0;
    logic [11:0] light;
    logic [1:0]  grant_id;
    logic        grant_vld, emg_active;

    intersection_phase_scheduler #(
        .N_APPR(4), .TICK_DIV(4), .MIN_GREEN(2), .MAX_GREEN(5),
        .YEL_TIME(2), .ALLRED_TIME(1), .CW(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .emg_valid(emg_valid), .emg_id(emg_id),
        .light(light), .grant_id(grant_id), .grant_vld(grant_vld), .emg_active(emg_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] light;
        logic        vld;
        logic [1:0]  gid;
        logic        emg;
        int          dmin;
        int          dmax;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done = 1'b0;

    logic [15:0] mon_last, mon_cur;
    int          mon_cyc = 0;
    int          mon_last_cyc = 0;
    bit          mon_primed = 1'b0;

    function automatic logic [11:0] lamp(int g, logic [2:0] c);
        logic [11:0] l;
        l = ALL_RED;
        l[3*g +: 3] = c;
        return l;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, need %0h", name, act, want);
        end
    endtask

    task automatic push_exp(logic [11:0] l, logic v, logic [1:0] g, logic e, int lo, int hi);
        exp_t x;
        x.light = l; x.vld = v; x.gid = g; x.emg = e; x.dmin = lo; x.dmax = hi;
        sb.push_back(x);
    endtask

    task automatic wait_for(string name, logic [11:0] target, int budget);
        int k;
        k = 0;
        while (light !== target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, light, target);
    endtask

    initial begin : monitor
        exp_t e;
        int   nred;
        int   dur;
        forever begin
            @(negedge clk);
            mon_cyc++;
            mon_cur = {light, grant_vld, grant_id, emg_active};
            if (!mon_primed) begin
                mon_primed   = 1'b1;
                mon_last     = mon_cur;
                mon_last_cyc = mon_cyc;
            end else if (mon_cur !== mon_last && !done) begin
                dur  = mon_cyc - mon_last_cyc;
                nred = 0;
                for (int i = 0; i < 4; i++) if (light[3*i +: 3] !== 3'b100) nred++;
                check("one_lamp", 32'(nred <= 1), 32'd1);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_change: got %0h, need no change", mon_cur);
                end else begin
                    e = sb.pop_front();
                    check("phase", mon_cur, {e.light, e.vld, e.gid, e.emg});
                    n_cmp++;
                    if (dur < e.dmin || dur > e.dmax) begin
                        n_bad++;
                        $display("FAIL phase_len: got %0d clk, need %0d..%0d", dur, e.dmin, e.dmax);
                    end
                end
                mon_last     = mon_cur;
                mon_last_cyc = mon_cyc;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, need finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset values, then idle with no requests.
        repeat (3) @(negedge clk);
        check("rst_light", light, ALL_RED);
        check("rst_vld", grant_vld, 1'b0);
        check("rst_gid", grant_id, 2'd0);
        check("rst_emg", emg_active, 1'b0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_light", light, ALL_RED);
        check("idle_vld", grant_vld, 1'b0);

        // Single request: one-clock latency, then rests in green.
        push_exp(lamp(2, 3'b001), 1'b1, 2'd2, 1'b0, 0, BIG);
        req = 4'b0100;
        @(posedge clk); #1;
        check("lat_light", light, lamp(2, 3'b001));
        check("lat_gid", grant_id, 2'd2);
        repeat (200) @(negedge clk);

        // Max-out rotation 2 -> 3 -> 0 with own requests held.
        push_exp(lamp(2, 3'b010), 1'b1, 2'd2, 1'b0, 200, BIG);
        push_exp(ALL_RED,         1'b0, 2'd2, 1'b0, 5, 8);
        push_exp(lamp(3, 3'b001), 1'b1, 2'd3, 1'b0, 1, 4);
        push_exp(lamp(3, 3'b010), 1'b1, 2'd3, 1'b0, 18, 21);
        push_exp(ALL_RED,         1'b0, 2'd3, 1'b0, 5, 8);
        push_exp(lamp(0, 3'b001), 1'b1, 2'd0, 1'b0, 1, 4);
        req = 4'b1101;
        wait_for("reach_g0", lamp(0, 3'b001), 200);

        // Gap-out after MIN_GREEN once own request drops.
        push_exp(lamp(0, 3'b010), 1'b1, 2'd0, 1'b0, 6, 9);
        push_exp(ALL_RED,         1'b0, 2'd0, 1'b0, 5, 8);
        push_exp(lamp(1, 3'b001), 1'b1, 2'd1, 1'b0, 1, 4);
        req = 4'b0010;
        wait_for("reach_g1", lamp(1, 3'b001), 100);

        // Pre-emption to 3: immediate yellow, green 3 held past MAX, then resume.
        push_exp(lamp(1, 3'b010), 1'b1, 2'd1, 1'b0, 1, 1);
        push_exp(ALL_RED,         1'b0, 2'd1, 1'b0, 5, 8);
        push_exp(lamp(3, 3'b001), 1'b1, 2'd3, 1'b1, 1, 4);
        push_exp(lamp(3, 3'b010), 1'b1, 2'd3, 1'b1, 61, 61);
        push_exp(ALL_RED,         1'b0, 2'd3, 1'b1, 5, 8);
        push_exp(lamp(2, 3'b001), 1'b1, 2'd2, 1'b0, 1, 4);
        emg_valid = 1'b1;
        emg_id    = 2'd3;
        req       = 4'b0100;
        wait_for("reach_g3_emg", lamp(3, 3'b001), 100);
        repeat (60) @(negedge clk);
        emg_valid = 1'b0;
        wait_for("reach_g2", lamp(2, 3'b001), 100);

        // Reset during yellow of approach 2, then restart with approaches 0 and 1 requesting.
        push_exp(lamp(2, 3'b010), 1'b1, 2'd2, 1'b0, 6, 9);
        push_exp(ALL_RED,         1'b0, 2'd0, 1'b0, 1, 1);
        req = 4'b0001;
        wait_for("reach_y2", lamp(2, 3'b010), 100);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_light", light, ALL_RED);
        check("midrst_vld", grant_vld, 1'b0);
        repeat (3) @(negedge clk);
        push_exp(lamp(0, 3'b001), 1'b1, 2'd0, 1'b0, 0, BIG);
        req   = 4'b0011;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_gid", grant_id, 2'd0);
        check("post_rst_light", light, lamp(0, 3'b001));
        repeat (4) @(negedge clk);
        done = 1'b1;
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
